matrix_multiplier: RTL and testbench

// - 2x2 single-precision (IEEE-754 binary32) matrix multiplier with load/ready/ack handshake.
// - Captures two packed 2x2 operand matrices and computes each output element as a 2-term dot product.
// - Uses one shared FP multiplier and one shared FP adder, sequenced by an FSM.
// - Standalone compute block; a host drives load, waits for out_ready, then pulses out_ack.

---
 rtl/matrix_multiplier.sv | 190 +++++++++++++++++++
 tb/tb_matrix_multiplier.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_multiplier.sv
// matrix_multiplier
//   2x2 IEEE-754 binary32 matrix multiplier built around one shared FP
//   multiplier and one shared FP adder. Each output element is a 2-term dot
//   product, sequenced as MUL0 -> MUL1 -> ADD, for c00, c01, c10, c11.
//   Denormals read as zero, results that underflow flush to zero, and
//   rounding is round-to-nearest-even.
// Ports
//   clk       clock, rising edge
//   rst       asynchronous reset, active low
//   In1       matrix A, row-major words {a11,a10,a01,a00}
//   In2       matrix B, column-major words {b11,b01,b10,b00}
//   load      start request, sampled in IDLE only
//   out_ack   result acknowledge, sampled in DONE only
//   Out       result C, row-major words {c11,c10,c01,c00}
//   out_ready C valid and held stable
module matrix_multiplier (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] In1,
  input  logic [127:0] In2,
  input  logic         load,
  input  logic         out_ack,
  output logic [127:0] Out,
  output logic         out_ready
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, ADD, DONE} state_t;

  state_t           state;
  logic [1:0]       idx;                 // element index: {i, j}
  logic [3:0][31:0] a_r, b_r, c_r;
  logic [31:0]      p0, p1;
  logic [31:0]      mul_a, mul_b, mul_y, add_y;
  logic             k;

  // Mantissa rounding shared by both units. m holds the 24-bit significand
  // plus guard and sticky; a carry out bumps the exponent.
  function automatic logic [31:0] pack_rnd(input logic s, input logic signed [9:0] e_in,
                                           input logic [23:0] m, input logic g, input logic st);
    logic [24:0]       mr;
    logic signed [9:0] e;
    logic [22:0]       frac;
    e    = e_in;
    mr   = {1'b0, m} + {24'b0, g & (st | m[0])};
    frac = mr[24] ? mr[23:1] : mr[22:0];
    if (mr[24]) e = e + 10'sd1;
    if (e >= 10'sd255)   pack_rnd = {s, 8'hFF, 23'b0};
    else if (e <= 10'sd0) pack_rnd = {s, 31'b0};
    else                  pack_rnd = {s, e[7:0], frac};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic              s, xn, yn, xi, yi, xz, yz;
    logic [47:0]       prod;
    logic signed [9:0] e;
    s  = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'b0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'b0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'b0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'b0);
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    if (xn || yn || (xi && yz) || (yi && xz)) fp_mul = QNAN;
    else if (xi || yi)                         fp_mul = {s, 8'hFF, 23'b0};
    else if (xz || yz)                         fp_mul = {s, 31'b0};
    else begin
      prod = {24'b0, 1'b1, x[22:0]} * {24'b0, 1'b1, y[22:0]};
      e    = $signed({2'b0, x[30:23]}) + $signed({2'b0, y[30:23]}) - 10'sd127;
      if (prod[47]) fp_mul = pack_rnd(s, e + 10'sd1, prod[47:24], prod[23], |prod[22:0]);
      else          fp_mul = pack_rnd(s, e,          prod[46:23], prod[22], |prod[21:0]);
    end
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic              xn, yn, xi, yi, xz, yz, found;
    logic [31:0]       l, sm;
    logic [7:0]        d;
    logic [26:0]       ml, ms;
    logic [53:0]       ext;
    logic [27:0]       sum;
    logic [4:0]        sh;
    logic signed [9:0] e;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'b0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'b0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'b0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'b0);
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    if (xn || yn || (xi && yi && (x[31] != y[31]))) fp_add = QNAN;
    else if (xi)       fp_add = x;
    else if (yi)       fp_add = y;
    else if (xz && yz) fp_add = {x[31] & y[31], 31'b0};
    else if (xz)       fp_add = y;
    else if (yz)       fp_add = x;
    else begin
      // Larger magnitude first so the subtraction never goes negative.
      if (x[30:0] < y[30:0]) begin l = y; sm = x; end
      else                   begin l = x; sm = y; end
      d  = l[30:23] - sm[30:23];
      ml = {1'b1, l[22:0], 3'b000};
      ext = {1'b1, sm[22:0], 3'b000, 27'b0} >> d;
      // Bit 0 of the aligned operand is the sticky bit.
      if (d > 8'd26) ms = 27'd1;
      else           ms = {ext[53:28], ext[27] | (|ext[26:0])};
      e = $signed({2'b0, l[30:23]});
      if (l[31] == sm[31]) begin
        sum = {1'b0, ml} + {1'b0, ms};
        if (sum[27]) begin
          sum = {1'b0, sum[27:2], sum[1] | sum[0]};
          e   = e + 10'sd1;
        end
      end else begin
        sum = {1'b0, ml - ms};
      end
      if (sum == 28'd0) fp_add = 32'h0;   // exact cancellation is +0
      else begin
        sh    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
          if (!found && sum[i]) begin
            found = 1'b1;
            sh    = 5'(26 - i);
          end
        end
        sum = sum << sh;
        e   = e - $signed({5'b0, sh});
        fp_add = pack_rnd(l[31], e, sum[26:3], sum[2], sum[1] | sum[0]);
      end
    end
  endfunction

  // Operand select: MUL0 uses k=0 terms (a_i0, b_0j), MUL1 the k=1 terms.
  always_comb begin
    k     = (state == MUL1);
    mul_a = a_r[{idx[1], k}];
    mul_b = b_r[{idx[0], k}];
  end

  assign mul_y = fp_mul(mul_a, mul_b);
  assign add_y = fp_add(p0, p1);
  assign Out   = c_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      a_r       <= '0;
      b_r       <= '0;
      c_r       <= '0;
      p0        <= '0;
      p1        <= '0;
      out_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          a_r   <= In1;
          b_r   <= In2;
          idx   <= 2'd0;
          state <= MUL0;
        end
        MUL0: begin
          p0    <= mul_y;
          state <= MUL1;
        end
        MUL1: begin
          p1    <= mul_y;
          state <= ADD;
        end
        ADD: begin
          c_r[idx] <= add_y;
          idx      <= idx + 2'd1;
          if (idx == 2'd3) begin
            state     <= DONE;
            out_ready <= 1'b1;
          end else begin
            state <= MUL0;
          end
        end
        DONE: if (out_ack) begin
          out_ready <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_multiplier.sv
// tb_matrix_multiplier
//   Directed vector table plus randomized operands against a real-number
//   reference model, with hand-written handshake, ignore and reset sequences.
module tb_matrix_multiplier;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic         out_ack = 1'b0;
  logic [127:0] In1 = '0;
  logic [127:0] In2 = '0;
  logic [127:0] Out;
  logic         out_ready;

  matrix_multiplier dut (
    .clk(clk), .rst(rst), .In1(In1), .In2(In2), .load(load),
    .out_ack(out_ack), .Out(Out), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] in1;
    logic [127:0] in2;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---- reference model: real arithmetic, each result rounded to binary32 ----
  function automatic real f2r(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 0.0;
    return $bitstoreal({x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [24:0] m;
    int          e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 896;
    m = {2'b01, b[51:29]};
    m = m + 25'(b[28] & ((|b[27:0]) | b[29]));
    if (m[24]) begin e++; m = m >> 1; end
    return {b[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [127:0] model(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] c;
    real          p0, p1;
    c = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        p0 = f2r(r2f(f2r(a[64*i +: 32])      * f2r(b[64*j +: 32])));
        p1 = f2r(r2f(f2r(a[64*i + 32 +: 32]) * f2r(b[64*j + 32 +: 32])));
        c[32*(2*i + j) +: 32] = r2f(p0 + p1);
      end
    return c;
  endfunction

  // Normal operand with a narrow exponent so the real-valued sum is exact.
  function automatic logic [31:0] rnd_word();
    logic       s;
    logic [7:0] e;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    e = 8'($urandom_range(124, 130));
    f = 23'($urandom);
    return {s, e, f};
  endfunction

  // ---- sequencing helpers ----
  task automatic start_op(input logic [127:0] a, input logic [127:0] b);
    @(negedge clk);
    In1  = a;
    In2  = b;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    In1  = rnd128();   // must be ignored after capture
    In2  = rnd128();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!out_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_ack(input string name, input logic [127:0] exp);
    @(negedge clk);
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
    check({name, " ack ready"}, 128'(out_ready), 128'(0));
    check({name, " ack held"}, Out, exp);
  endtask

  task automatic run_op(input string name, input logic [127:0] a, input logic [127:0] b,
                        input logic [127:0] exp);
    int n;
    start_op(a, b);
    wait_ready(n);
    check({name, " latency"}, 128'(n), 128'(12));
    check({name, " out"}, Out, exp);
    do_ack(name, exp);
  endtask

  initial begin
    int           n;
    logic [127:0] a, b, e;

    // basic {4,3,2,1} x {4,3,2,1}
    vecs[0] = '{128'h40800000_40400000_40000000_3F800000,
                128'h40800000_40400000_40000000_3F800000,
                128'h41C80000_41300000_41300000_40A00000};
    // signs and exact cancellation
    vecs[1] = '{128'h40400000_40000000_BF800000_3F800000,
                128'h00000000_C0000000_3F800000_3F800000,
                128'hC0800000_40A00000_C0000000_00000000};
    // Inf*0 -> NaN, finite*Inf -> Inf
    vecs[2] = '{128'h40400000_40000000_3F800000_7F800000,
                128'h00000000_40000000_3F800000_00000000,
                128'h40800000_40400000_7F800000_7FC00000};
    // 1e38*1e38 overflow, +0 + -0
    vecs[3] = '{128'h00000000_00000000_3F800000_7E967699,
                128'hBF800000_00000000_3F800000_7E967699,
                128'h00000000_00000000_BF800000_7F800000};
    // underflow flush and NaN input
    vecs[4] = '{128'h00000000_3F800000_7F800001_0D800000,
                128'h00000000_00000000_0D800000_0D800000,
                128'h00000000_0D800000_7FC00000_7FC00000};

    // reset with garbage inputs
    In1  = rnd128();
    In2  = rnd128();
    load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset out", Out, '0);
    check("reset ready", 128'(out_ready), 128'(0));
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle out", Out, '0);
    check("idle ready", 128'(out_ready), 128'(0));

    for (int i = 0; i < 5; i++)
      run_op($sformatf("vec%0d", i), vecs[i].in1, vecs[i].in2, vecs[i].exp);

    // DONE holds for 5 cycles with ack low and load ignored
    start_op(vecs[0].in1, vecs[0].in2);
    wait_ready(n);
    check("hold latency", 128'(n), 128'(12));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      load = 1'b1;
      In1  = rnd128();
      In2  = rnd128();
      @(posedge clk);
      #1;
      check("hold out", Out, vecs[0].exp);
      check("hold ready", 128'(out_ready), 128'(1));
    end
    // ack with load still high: IDLE next edge, capture on the one after
    @(negedge clk);
    out_ack = 1'b1;
    In1     = vecs[1].in1;
    In2     = vecs[1].in2;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
    check("reload ack ready", 128'(out_ready), 128'(0));
    check("reload ack held", Out, vecs[0].exp);
    @(posedge clk);
    #1;
    load = 1'b0;
    In1  = rnd128();
    In2  = rnd128();
    wait_ready(n);
    check("reload latency", 128'(n), 128'(12));
    check("reload out", Out, vecs[1].exp);
    do_ack("reload", vecs[1].exp);

    // out_ack during computation is ignored
    start_op(vecs[2].in1, vecs[2].in2);
    out_ack = 1'b1;
    n = 0;
    while (!out_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 4) out_ack = 1'b0;
    end
    check("early ack latency", 128'(n), 128'(12));
    check("early ack out", Out, vecs[2].exp);
    do_ack("early ack", vecs[2].exp);

    // reset mid-computation, after c00/c01 have been written
    start_op(vecs[0].in1, vecs[0].in2);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midreset out", Out, '0);
    check("midreset ready", 128'(out_ready), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    run_op("after reset", vecs[0].in1, vecs[0].in2, vecs[0].exp);

    // randomized operands against the model
    for (int t = 0; t < 20; t++) begin
      for (int w = 0; w < 4; w++) begin
        a[32*w +: 32] = rnd_word();
        b[32*w +: 32] = rnd_word();
      end
      e = model(a, b);
      run_op($sformatf("rand%0d", t), a, b, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
